// File: rtl/norm_lzc_ctrl.sv
// Normalisation controller: finds the leading-zero count of a 32-bit operand
// with a 5-step binary search. It then drives an external combinational left
// shifter and registers the normalised word together with the count.
module norm_lzc_ctrl #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned CNT_W       = 5,
    parameter bit          BYPASS_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] sh_a,
    output logic [CNT_W-1:0]  sh_cnt,
    input  logic [DATA_W-1:0] sh_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W:0]    out_lzc,
    output logic              out_zero
);

    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

    state_t              state, state_nx;
    logic [DATA_W-1:0]   opnd;
    logic [DATA_W-1:0]   w;
    logic [DATA_W-1:0]   w_sh;
    logic [CNT_W:0]      lzc;
    logic [CNT_W:0]      step_k;
    logic [2:0]          step;
    logic                top_zero;
    logic                zflag;
    logic                accept;
    logic                in_is_zero;

    assign sh_a       = opnd;
    assign in_is_zero = (in_data == '0);

    // Decode the current search step: width k and whether the top k bits of w are clear.
    always_comb begin
        step_k   = '0;
        top_zero = 1'b0;
        case (step)
            3'd0: begin step_k = (CNT_W+1)'(16); top_zero = (w[31:16] == '0); end
            3'd1: begin step_k = (CNT_W+1)'(8);  top_zero = (w[31:24] == '0); end
            3'd2: begin step_k = (CNT_W+1)'(4);  top_zero = (w[31:28] == '0); end
            3'd3: begin step_k = (CNT_W+1)'(2);  top_zero = (w[31:30] == '0); end
            default: begin step_k = (CNT_W+1)'(1); top_zero = ~w[31]; end
        endcase
        w_sh = top_zero ? (w << step_k) : w;
    end

    // Next-state logic and state-decoded handshake/shifter outputs.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        sh_cnt    = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_nx = (in_is_zero && BYPASS_ZERO) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (step == 3'd4) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                // A zero operand carries lzc=32, so the low bits give a zero shift.
                sh_cnt   = lzc[CNT_W-1:0];
                state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Operand capture, binary-search datapath and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opnd     <= '0;
            w        <= '0;
            lzc      <= '0;
            step     <= '0;
            zflag    <= 1'b0;
            out_data <= '0;
            out_lzc  <= '0;
            out_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        opnd  <= in_data;
                        w     <= in_data;
                        lzc   <= '0;
                        step  <= '0;
                        zflag <= in_is_zero;
                        if (in_is_zero && BYPASS_ZERO) begin
                            out_data <= '0;
                            out_lzc  <= (CNT_W+1)'(DATA_W);
                            out_zero <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    w    <= w_sh;
                    step <= step + 3'd1;
                    if (top_zero) begin
                        lzc <= lzc + step_k;
                    end
                    // After the last step a still-clear MSB means the operand was zero.
                    if (step == 3'd4 && !w_sh[31]) begin
                        lzc <= (CNT_W+1)'(DATA_W);
                    end
                end
                SHIFT: begin
                    out_data <= zflag ? '0 : sh_b;
                    out_lzc  <= lzc;
                    out_zero <= zflag;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_norm_lzc_ctrl.sv
// Self-checking bench for norm_lzc_ctrl: one instance per BYPASS_ZERO setting,
// sharing stimulus, each with its own model of the external shifter.
module tb_norm_lzc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready0, in_ready1;
    logic [31:0] sh_a0, sh_a1, sh_b0, sh_b1;
    logic [4:0]  sh_cnt0, sh_cnt1;
    logic        out_valid0, out_valid1;
    logic [31:0] out_data0, out_data1;
    logic [5:0]  out_lzc0, out_lzc1;
    logic        out_zero0, out_zero1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  lzc;
        logic [31:0] odata;
        logic        zero;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    assign sh_b0 = sh_a0 << sh_cnt0;
    assign sh_b1 = sh_a1 << sh_cnt1;

    norm_lzc_ctrl #(.DATA_W(32), .CNT_W(5), .BYPASS_ZERO(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .sh_a(sh_a0), .sh_cnt(sh_cnt0), .sh_b(sh_b0),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_lzc(out_lzc0), .out_zero(out_zero0)
    );

    norm_lzc_ctrl #(.DATA_W(32), .CNT_W(5), .BYPASS_ZERO(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .sh_a(sh_a1), .sh_cnt(sh_cnt1), .sh_b(sh_b1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_lzc(out_lzc1), .out_zero(out_zero1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(in_ready0 && in_ready1) && t < 50) begin
            tick();
            t++;
        end
        chk("idle_wait", {31'b0, in_ready0 && in_ready1}, 32'd1);
    endtask

    task automatic wait_valid0();
        int t = 0;
        while (!out_valid0 && t < 30) begin
            tick();
            t++;
        end
        chk("valid_wait", {31'b0, out_valid0}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int          k0 = -1, k1 = -1;
        logic [31:0] d0 = 'x, d1 = 'x;
        logic [5:0]  l0 = 'x, l1 = 'x;
        logic        z0 = 1'bx, z1 = 1'bx;
        logic [4:0]  sc = 'x;
        logic [4:0]  sc_pre = 'x;
        wait_idle();
        in_valid = 1'b1;
        in_data  = v.data;
        tick();
        in_valid = 1'b0;
        chk("sh_a", sh_a0, v.data);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) tick();
            if (k == 4) sc_pre = sh_cnt0;
            if (k == 5) sc = sh_cnt0;
            if (out_valid0 && k0 < 0) begin
                k0 = k; d0 = out_data0; l0 = out_lzc0; z0 = out_zero0;
            end
            if (out_valid1 && k1 < 0) begin
                k1 = k; d1 = out_data1; l1 = out_lzc1; z1 = out_zero1;
            end
        end
        chk("lat_full", k0 + 1, 32'd7);
        chk("lat_bypass", k1 + 1, v.zero ? 32'd1 : 32'd7);
        chk("data_full", d0, v.odata);
        chk("lzc_full", {26'b0, l0}, {26'b0, v.lzc});
        chk("zero_full", {31'b0, z0}, {31'b0, v.zero});
        chk("data_bypass", d1, v.odata);
        chk("lzc_bypass", {26'b0, l1}, {26'b0, v.lzc});
        chk("zero_bypass", {31'b0, z1}, {31'b0, v.zero});
        chk("sh_cnt_scan", {27'b0, sc_pre}, 32'd0);
        chk("sh_cnt_shift", {27'b0, sc}, {27'b0, v.lzc[4:0]});
    endtask

    initial begin
        int seen;

        vecs[0] = '{32'h0000_0001, 6'd31, 32'h8000_0000, 1'b0};
        vecs[1] = '{32'h8000_0000, 6'd0,  32'h8000_0000, 1'b0};
        vecs[2] = '{32'h0001_2345, 6'd15, 32'h91A2_8000, 1'b0};
        vecs[3] = '{32'h0000_0000, 6'd32, 32'h0000_0000, 1'b1};
        vecs[4] = '{32'hFFFF_FFFF, 6'd0,  32'hFFFF_FFFF, 1'b0};
        vecs[5] = '{32'h0000_8000, 6'd16, 32'h8000_0000, 1'b0};
        vecs[6] = '{32'h4000_0000, 6'd1,  32'h8000_0000, 1'b0};
        vecs[7] = '{32'h0000_0003, 6'd30, 32'hC000_0000, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", {31'b0, in_ready0}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid0}, 32'd0);
        chk("rst_sh_a", sh_a0, 32'd0);
        chk("rst_sh_cnt", {27'b0, sh_cnt0}, 32'd0);
        chk("rst_out_data", out_data0, 32'd0);
        chk("rst_out_lzc", {26'b0, out_lzc0}, 32'd0);
        chk("rst_out_zero", {31'b0, out_zero1}, 32'd0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure in DONE, with a second operand waiting upstream.
        out_ready = 1'b0;
        wait_idle();
        in_valid = 1'b1;
        in_data  = 32'h00F0_0000;
        tick();
        in_valid = 1'b0;
        wait_valid0();
        in_valid = 1'b1;
        in_data  = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", {31'b0, out_valid0}, 32'd1);
            chk("hold_data", out_data0, 32'hF000_0000);
            chk("hold_lzc", {26'b0, out_lzc0}, 32'd8);
            chk("hold_in_ready", {31'b0, in_ready0}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("hs_in_ready", {31'b0, in_ready0}, 32'd1);
        chk("hs_out_valid", {31'b0, out_valid0}, 32'd0);
        chk("hs_no_accept", sh_a0, 32'h00F0_0000);
        tick();
        chk("next_accept", sh_a0, 32'h0000_0100);
        chk("next_busy", {31'b0, in_ready0}, 32'd0);
        in_valid = 1'b0;
        wait_valid0();
        chk("next_data", out_data0, 32'h8000_0000);
        chk("next_lzc", {26'b0, out_lzc0}, 32'd23);

        // Reset in the middle of the search discards the operand.
        wait_idle();
        in_valid = 1'b1;
        in_data  = 32'h0000_0001;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_in_ready", {31'b0, in_ready0}, 32'd1);
        chk("mid_rst_out_valid", {31'b0, out_valid0}, 32'd0);
        chk("mid_rst_sh_cnt", {27'b0, sh_cnt0}, 32'd0);
        chk("mid_rst_sh_a", sh_a0, 32'd0);
        chk("mid_rst_out_data", out_data0, 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid0 || out_valid1) seen++;
        end
        chk("mid_rst_no_stale", seen, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
